// File: rtl/alu_pkg.sv
// alu_pkg: opcode, shift-code and FSM state encodings shared by the multi-cycle ALU
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_ADC,
        ALU_SUB,
        ALU_SBC,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_MOV
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SHL,
        SH_SAR,
        SH_ROL,
        SH_ROR
    } sh_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXEC
    } state_e;

endpackage

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: shift-amount clamp/mod and the one-bit-per-cycle shift/rotate step
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             i_load,
    input  logic [1:0]       i_scode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_work,
    input  logic [SHW-1:0]   i_cnt,
    output logic [SHW-1:0]   o_n,
    output logic [WIDTH-1:0] o_next,
    output logic             o_bit,
    output logic [SHW-1:0]   o_cnt,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

    logic             w_rot;
    logic             w_left;
    logic [WIDTH-1:0] w_src;
    logic [SHW-1:0]   w_cnt;

    // On load the step works straight from the operand so the first bit moves in the accept cycle
    always_comb begin
        w_rot  = i_scode == SH_ROL || i_scode == SH_ROR;
        w_left = i_scode == SH_SHL || i_scode == SH_ROL;
        o_n    = w_rot ? SHW'(i_b % LP_W) : (i_b > LP_W ? SHW'(LP_W) : SHW'(i_b));
        w_src  = i_load ? i_a : i_work;
        w_cnt  = i_load ? o_n : i_cnt;
        o_next = w_left ? {w_src[WIDTH-2:0], w_rot ? w_src[WIDTH-1] : 1'b0}
                        : {w_rot ? w_src[0] : w_src[WIDTH-1], w_src[WIDTH-1:1]};
        o_bit  = w_left ? w_src[WIDTH-1] : w_src[0];
        o_cnt  = w_cnt - SHW'(1);
        o_last = w_cnt == SHW'(1);
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with flag register, start/done handshake and iterative shifter
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_shift,
    input  logic [1:0]       scode,
    input  logic [2:0]       acode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_scode;

    logic             w_load;
    logic             w_step;
    logic             w_commit;
    logic             w_bit;
    logic             w_last;
    logic             w_sub;
    logic             w_cin;
    logic             w_c;
    logic             w_v;
    logic [SHW-1:0]   w_n;
    logic [SHW-1:0]   w_cnt;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_bop;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;

    assign w_load = r_state == ST_IDLE;
    assign busy   = r_state == ST_EXEC;

    alu_shift_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift (
        .i_load  (w_load),
        .i_scode (w_load ? scode : r_scode),
        .i_a     (a),
        .i_b     (b),
        .i_work  (r_work),
        .i_cnt   (r_cnt),
        .o_n     (w_n),
        .o_next  (w_next),
        .o_bit   (w_bit),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

    // The result is committed one edge early so done, r and the flags share the last EXEC cycle
    always_comb begin
        w_state_nxt = w_load ? (start ? ST_EXEC : ST_IDLE) : (done ? ST_IDLE : ST_EXEC);
        w_step      = w_load ? start : !done;
        w_commit    = w_load ? start && (!is_shift || w_n == '0 || w_last) : !done && w_last;
    end

    always_comb begin
        w_sub   = acode == ALU_SUB || acode == ALU_SBC;
        w_bop   = w_sub ? ~b : b;
        w_cin   = acode == ALU_SUB || ((acode == ALU_ADC || acode == ALU_SBC) && carry);
        w_sum   = {1'b0, a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
        w_logic = acode == ALU_AND ? a & b : acode == ALU_OR ? a | b : acode == ALU_XOR ? a ^ b : b;
        w_res   = w_next;
        w_c     = w_bit;
        w_v     = 1'b0;
        if (w_load && !is_shift) begin
            w_res = acode[2] ? w_logic : w_sum[WIDTH-1:0];
            w_c   = !acode[2] && w_sum[WIDTH];
            w_v   = !acode[2] && a[WIDTH-1] == w_bop[WIDTH-1] && w_sum[WIDTH-1] != a[WIDTH-1];
        end else if (w_load && w_n == '0) begin
            w_res = a;
            w_c   = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_cnt   <= '0;
            r_scode <= '0;
            done    <= 1'b0;
            r       <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= w_commit;
            if (w_step) begin
                r_work <= w_next;
                r_cnt  <= w_cnt;
            end
            if (w_load) r_scode <= scode;
            if (w_commit) begin
                r     <= w_res;
                zero  <= w_res == '0;
                carry <= w_c;
                neg   <= w_res[WIDTH-1];
                ovf   <= w_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc at WIDTH=8
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       is_shift = 1'b0;
    logic [1:0] scode = '0;
    logic [2:0] acode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, zero, carry, neg, ovf;
    logic [7:0] r;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] r;
        logic       c;
        logic       v;
        int         lat;
    } exp_t;

    exp_t sb[$];

    alu_mc #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_shift (is_shift),
        .scode    (scode),
        .acode    (acode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .r        (r),
        .zero     (zero),
        .carry    (carry),
        .neg      (neg),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sh, input logic [1:0] sc, input logic [2:0] ac,
                          input logic [7:0] av, input logic [7:0] bv, input logic [7:0] er,
                          input logic ec, input logic ev, input int elat, input bit hold);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        is_shift = sh;
        scode    = sc;
        acode    = ac;
        a        = av;
        b        = bv;
        start    = 1'b1;
        e.tag = tag;
        e.r   = er;
        e.c   = ec;
        e.v   = ev;
        e.lat = elat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            chk({tag, "_busy"}, busy, 1);
            got = done;
        end
        chk({tag, "_done_seen"}, got, 1);
        e = sb.pop_front();
        chk({e.tag, "_latency"}, lat, e.lat);
        chk({e.tag, "_r"}, r, e.r);
        chk({e.tag, "_zero"}, zero, e.r == 8'h00);
        chk({e.tag, "_carry"}, carry, e.c);
        chk({e.tag, "_neg"}, neg, e.r[7]);
        chk({e.tag, "_ovf"}, ovf, e.v);
        @(negedge clk);
        chk({e.tag, "_done_pulse"}, done, 0);
        chk({e.tag, "_idle_after"}, busy, 0);
        start = 1'b0;
    endtask

    initial begin
        int nd;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_r", r, 0);
        chk("rst_flags", {zero, carry, neg, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_ovf",  0, SH_SHL, ALU_ADD, 8'h7F, 8'h01, 8'h80, 0, 1, 1, 0);
        run_op("add_wrap", 0, SH_SHL, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0);
        run_op("adc_cin",  0, SH_SHL, ALU_ADC, 8'h00, 8'h00, 8'h01, 0, 0, 1, 0);
        run_op("sub_eq",   0, SH_SHL, ALU_SUB, 8'h05, 8'h05, 8'h00, 1, 0, 1, 0);
        run_op("sbc_nb",   0, SH_SHL, ALU_SBC, 8'h10, 8'h01, 8'h0F, 1, 0, 1, 0);
        run_op("sar3",     1, SH_SAR, ALU_ADD, 8'h81, 8'h03, 8'hF0, 0, 0, 3, 0);
        run_op("rol1",     1, SH_ROL, ALU_ADD, 8'h81, 8'h01, 8'h03, 1, 0, 1, 0);
        run_op("sar0",     1, SH_SAR, ALU_ADD, 8'h81, 8'h00, 8'h81, 1, 0, 1, 0);
        run_op("ror9",     1, SH_ROR, ALU_ADD, 8'h81, 8'h09, 8'hC0, 1, 0, 1, 0);
        run_op("shl200",   1, SH_SHL, ALU_ADD, 8'h01, 8'd200, 8'h00, 1, 0, 8, 0);
        run_op("and",      0, SH_SHL, ALU_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 1, 0);
        run_op("or",       0, SH_SHL, ALU_OR,  8'hF0, 8'h3C, 8'hFC, 0, 0, 1, 0);
        run_op("xor",      0, SH_SHL, ALU_XOR, 8'hF0, 8'h3C, 8'hCC, 0, 0, 1, 0);
        run_op("mov",      0, SH_SHL, ALU_MOV, 8'hAA, 8'h00, 8'h00, 0, 0, 1, 0);
        run_op("ror3",     1, SH_ROR, ALU_ADD, 8'h01, 8'h03, 8'h20, 0, 0, 3, 0);
        run_op("sar8",     1, SH_SAR, ALU_ADD, 8'h40, 8'h08, 8'h00, 0, 0, 8, 0);
        run_op("shl_hold", 1, SH_SHL, ALU_ADD, 8'h01, 8'h08, 8'h00, 1, 0, 8, 1);
        run_op("sub_ovf",  0, SH_SHL, ALU_SUB, 8'h80, 8'h01, 8'h7F, 1, 1, 1, 0);

        @(negedge clk);
        is_shift = 1'b1;
        scode    = SH_SAR;
        a        = 8'h81;
        b        = 8'h05;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_r", r, 0);
        chk("midrst_flags", {zero, carry, neg, ovf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst_no_done", nd, 0);
        chk("midrst_idle", busy, 0);
        run_op("adc_after_rst", 0, SH_SHL, ALU_ADC, 8'h01, 8'h01, 8'h02, 0, 0, 1, 0);
        run_op("add_after_rst", 0, SH_SHL, ALU_ADD, 8'h02, 8'h03, 8'h05, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
